// File: rtl/bullet_pkg.sv
// Grid constants, direction encoding and slot record shared by the bullet pool logic.
// Latency/backpressure: none (types and pure functions only).
package bullet_pkg;
  localparam int GRID_W = 16;
  localparam int GRID_H = 20;
  localparam int POS_W  = 5;
  localparam int OWN_W  = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef struct packed {
    logic             active;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    dir_e             dir;
    logic [OWN_W-1:0] owner;
  } slot_t;

  // True when one step in direction d from (x,y) would fall off the playfield.
  function automatic logic step_leaves_grid(input logic [POS_W-1:0] x,
                                            input logic [POS_W-1:0] y,
                                            input dir_e d);
    logic leaves;
    leaves = 1'b0;
    case (d)
      DIR_UP:    leaves = (y == '0);
      DIR_DOWN:  leaves = (y == POS_W'(GRID_H - 1));
      DIR_LEFT:  leaves = (x == '0);
      DIR_RIGHT: leaves = (x == POS_W'(GRID_W - 1));
      default:   leaves = 1'b0;
    endcase
    return leaves;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer moves past each winner.
// Latency: grant same cycle as req; backpressure: none, losers simply keep requesting.
module rr_arbiter
  import bullet_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && req[(int'(ptr) + i) % N]) begin
        gnt_vld                  = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gnt_idx                  = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
endmodule

// File: rtl/bullet_slot_ctrl.sv
// Bullet slot pool: round-robin fire arbitration, slot load, per-tick move/retire, kill. Option BULLET_ONE_PER_OWNER_EN.
// Latency: 1 cycle req->gnt/nack and tick/kill->slot outputs; a full pool holds requests pending (no gnt, no nack).
module bullet_slot_ctrl
  import bullet_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int N_SLOT = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           move_tick,
  input  logic [N_REQ-1:0]               fire_req,
  input  logic [2*N_REQ-1:0]             fire_dir,
  input  logic [POS_W*N_REQ-1:0]         fire_x,
  input  logic [POS_W*N_REQ-1:0]         fire_y,
  input  logic [N_SLOT-1:0]              kill,
  output logic [N_REQ-1:0]               fire_gnt,
  output logic [N_REQ-1:0]               fire_nack,
  output logic [N_SLOT-1:0]              slot_active,
  output logic [POS_W*N_SLOT-1:0]        slot_x,
  output logic [POS_W*N_SLOT-1:0]        slot_y,
  output logic [2*N_SLOT-1:0]            slot_dir,
  output logic [$clog2(N_REQ)*N_SLOT-1:0] slot_owner
);
  localparam int OW = $clog2(N_REQ);
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  slot_t            slots_q [N_SLOT];
  slot_t            slots_d [N_SLOT];
  logic [N_REQ-1:0] owner_busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_gnt;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] nack_d;
  logic [OW-1:0]    arb_idx;
  logic             arb_vld;
  logic [POS_W-1:0] sel_x;
  logic [POS_W-1:0] sel_y;
  dir_e             sel_dir;
  logic             sel_bad;
  logic [SW-1:0]    free_idx;
  logic             free_vld;
  logic             unused_owner;

  // Lowest-index free slot; freeing on this edge is not visible until the next one.
  always_comb begin
    free_idx = '0;
    free_vld = 1'b0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      if (!slots_q[s].active) begin
        free_idx = SW'(s);
        free_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_busy = '0;
`ifdef BULLET_ONE_PER_OWNER_EN
    for (int s = 0; s < N_SLOT; s++) begin
      if (slots_q[s].active) owner_busy[slots_q[s].owner[OW-1:0]] = 1'b1;
    end
`endif
  end

  // A requester still seeing its own gnt/nack pulse cannot win again this edge.
  assign elig = fire_req & ~(fire_gnt | fire_nack) & ~owner_busy & {N_REQ{free_vld}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (elig),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign sel_x   = fire_x[int'(arb_idx)*POS_W +: POS_W];
  assign sel_y   = fire_y[int'(arb_idx)*POS_W +: POS_W];
  assign sel_dir = dir_e'(fire_dir[int'(arb_idx)*2 +: 2]);
  assign sel_bad = (sel_x > POS_W'(GRID_W - 1)) || (sel_y > POS_W'(GRID_H - 1));

  assign gnt_d  = (arb_vld && !sel_bad) ? arb_gnt : '0;
  assign nack_d = (arb_vld &&  sel_bad) ? arb_gnt : '0;

  always_comb begin
    for (int s = 0; s < N_SLOT; s++) begin
      slots_d[s] = slots_q[s];
      if (slots_q[s].active) begin
        if (kill[s]) begin
          slots_d[s].active = 1'b0;
        end else if (move_tick) begin
          if (step_leaves_grid(slots_q[s].x, slots_q[s].y, slots_q[s].dir)) begin
            slots_d[s].active = 1'b0;
          end else begin
            case (slots_q[s].dir)
              DIR_UP:    slots_d[s].y = slots_q[s].y - POS_W'(1);
              DIR_DOWN:  slots_d[s].y = slots_q[s].y + POS_W'(1);
              DIR_LEFT:  slots_d[s].x = slots_q[s].x - POS_W'(1);
              DIR_RIGHT: slots_d[s].x = slots_q[s].x + POS_W'(1);
              default:   slots_d[s].x = slots_q[s].x;
            endcase
          end
        end
      end else if (arb_vld && !sel_bad && (free_idx == SW'(s))) begin
        slots_d[s].active = 1'b1;
        slots_d[s].x      = sel_x;
        slots_d[s].y      = sel_y;
        slots_d[s].dir    = sel_dir;
        slots_d[s].owner  = OWN_W'(arb_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_gnt  <= '0;
      fire_nack <= '0;
      for (int s = 0; s < N_SLOT; s++) slots_q[s] <= '0;
    end else begin
      fire_gnt  <= gnt_d;
      fire_nack <= nack_d;
      for (int s = 0; s < N_SLOT; s++) slots_q[s] <= slots_d[s];
    end
  end

  always_comb begin
    slot_active  = '0;
    slot_x       = '0;
    slot_y       = '0;
    slot_dir     = '0;
    slot_owner   = '0;
    unused_owner = 1'b0;
    for (int s = 0; s < N_SLOT; s++) begin
      slot_active[s]              = slots_q[s].active;
      slot_x[s*POS_W +: POS_W]    = slots_q[s].x;
      slot_y[s*POS_W +: POS_W]    = slots_q[s].y;
      slot_dir[s*2 +: 2]          = slots_q[s].dir;
      slot_owner[s*OW +: OW]      = slots_q[s].owner[OW-1:0];
      unused_owner                = unused_owner ^ (^slots_q[s].owner);
    end
  end
endmodule
